// File: rtl/bfly_twiddle_mul.sv
// bfly_twiddle_mul: twiddle rotation stage after the radix-2 butterfly.
// The sum path is delay-matched; the difference path is multiplied by W_N^k.
module bfly_twiddle_mul #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 11,
    parameter int TW_WIDTH  = 9,
    parameter int FFT_N     = 512,
    parameter int TW_STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [IN_WIDTH-1:0]          din1_re,
    input  logic [IN_WIDTH-1:0]          din1_im,
    input  logic [IN_WIDTH-1:0]          din2_re,
    input  logic [IN_WIDTH-1:0]          din2_im,
    input  logic                         valid_in,
    output logic [OUT_WIDTH-1:0]         dout1_re,
    output logic [OUT_WIDTH-1:0]         dout1_im,
    output logic [OUT_WIDTH-1:0]         dout2_re,
    output logic [OUT_WIDTH-1:0]         dout2_im,
    output logic                         valid_out,
    output logic [$clog2(FFT_N/2)-1:0]   tw_idx,
    output logic                         sat_flag
);

    localparam int KW   = $clog2(FFT_N / 2);
    localparam int AW   = $clog2(FFT_N);
    localparam int PW   = IN_WIDTH + TW_WIDTH;
    localparam int SW   = PW + 1;
    localparam int TPW  = 2 * TW_WIDTH;
    localparam int FRAC = TW_WIDTH - 2;

    localparam logic [KW-1:0]        K_LAST  = KW'(FFT_N / 2 - 1);
    localparam logic signed [SW-1:0] RND_C   = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] O_MAX   = SW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] O_MIN   = SW'(-(2 ** (OUT_WIDTH - 1)));
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Fixed-point Q30 constants for the table generator.
    localparam longint PI_Q30 = 64'sd3373259426;
    localparam longint ONE_Q  = 64'sd1073741824;
    localparam longint HALF_Q = 64'sd536870912;

    // Builds the twiddle ROM: entry a holds {im, re} with
    // re = round(128*cos(2*pi*a/N)), im = round(-128*sin(2*pi*a/N)).
    // The angle is folded into the first quadrant, sin/cos come from a
    // Q30 Taylor series, and rounding is applied to the magnitude so that
    // restoring the quadrant sign rounds half away from zero.
    function automatic logic [FFT_N*TPW-1:0] tw_gen();
        logic [FFT_N*TPW-1:0] t;
        longint q, r, x, s, c, ts, tc, n2, rs, rc, cr, sr;
        t = '0;
        for (int a = 0; a < FFT_N; a++) begin
            q  = longint'(a / (FFT_N / 4));
            r  = longint'(a % (FFT_N / 4));
            x  = (r * 64'sd2 * PI_Q30) / longint'(FFT_N);
            s  = x;
            c  = ONE_Q;
            ts = x;
            tc = ONE_Q;
            for (int n = 1; n < 12; n++) begin
                n2 = longint'(2 * n);
                ts = -((((ts * x) >>> 30) * x) >>> 30)
                     / (n2 * (n2 + 64'sd1));
                tc = -((((tc * x) >>> 30) * x) >>> 30)
                     / ((n2 - 64'sd1) * n2);
                s  = s + ts;
                c  = c + tc;
            end
            if (s < 64'sd0) s = 64'sd0;
            if (c < 64'sd0) c = 64'sd0;
            rs = (s * 64'sd128 + HALF_Q) >>> 30;
            rc = (c * 64'sd128 + HALF_Q) >>> 30;
            if (q == 64'sd0) begin
                cr = rc;
                sr = rs;
            end else if (q == 64'sd1) begin
                cr = -rs;
                sr = rc;
            end else if (q == 64'sd2) begin
                cr = -rc;
                sr = -rs;
            end else begin
                cr = rs;
                sr = -rc;
            end
            t[a*TPW +: TW_WIDTH]            = TW_WIDTH'(cr);
            t[a*TPW + TW_WIDTH +: TW_WIDTH] = TW_WIDTH'(-sr);
        end
        return t;
    endfunction

    localparam logic [FFT_N*TPW-1:0] TW_TBL = tw_gen();

    logic [31:0]                 addr_prod;
    logic [AW-1:0]               tw_addr;
    logic signed [TW_WIDTH-1:0]  tw_re_c;
    logic signed [TW_WIDTH-1:0]  tw_im_c;

    logic                        s1_v;
    logic signed [IN_WIDTH-1:0]  s1_d1r;
    logic signed [IN_WIDTH-1:0]  s1_d1i;
    logic signed [IN_WIDTH-1:0]  s1_ar;
    logic signed [IN_WIDTH-1:0]  s1_ai;
    logic signed [TW_WIDTH-1:0]  s1_wr;
    logic signed [TW_WIDTH-1:0]  s1_wi;

    logic                        s2_v;
    logic signed [IN_WIDTH-1:0]  s2_d1r;
    logic signed [IN_WIDTH-1:0]  s2_d1i;
    logic signed [PW-1:0]        p_rr;
    logic signed [PW-1:0]        p_ii;
    logic signed [PW-1:0]        p_ri;
    logic signed [PW-1:0]        p_ir;

    logic signed [SW-1:0]        re_sum;
    logic signed [SW-1:0]        im_sum;
    logic signed [SW-1:0]        re_rnd;
    logic signed [SW-1:0]        im_rnd;
    logic [OUT_WIDTH-1:0]        re_o;
    logic [OUT_WIDTH-1:0]        im_o;
    logic                        re_clip;
    logic                        im_clip;

    // Sample index k: advances per accepted sample, wraps at N/2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tw_idx <= '0;
        end else if (valid_in) begin
            if (tw_idx == K_LAST) tw_idx <= '0;
            else                  tw_idx <= tw_idx + KW'(1);
        end
    end

    // Table address (k*stride) mod N and ROM read for the current k.
    always_comb begin
        addr_prod = 32'(tw_idx) * 32'(TW_STRIDE);
        tw_addr   = AW'(addr_prod % 32'(FFT_N));
        tw_re_c   = TW_TBL[int'(tw_addr)*TPW +: TW_WIDTH];
        tw_im_c   = TW_TBL[int'(tw_addr)*TPW + TW_WIDTH +: TW_WIDTH];
    end

    // S1: capture both input pairs and the twiddle for this sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v   <= 1'b0;
            s1_d1r <= '0;
            s1_d1i <= '0;
            s1_ar  <= '0;
            s1_ai  <= '0;
            s1_wr  <= '0;
            s1_wi  <= '0;
        end else begin
            s1_v <= valid_in;
            if (valid_in) begin
                s1_d1r <= $signed(din1_re);
                s1_d1i <= $signed(din1_im);
                s1_ar  <= $signed(din2_re);
                s1_ai  <= $signed(din2_im);
                s1_wr  <= tw_re_c;
                s1_wi  <= tw_im_c;
            end
        end
    end

    // S2: the four partial products, sum path rides alongside.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_v   <= 1'b0;
            s2_d1r <= '0;
            s2_d1i <= '0;
            p_rr   <= '0;
            p_ii   <= '0;
            p_ri   <= '0;
            p_ir   <= '0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_d1r <= s1_d1r;
                s2_d1i <= s1_d1i;
                p_rr   <= s1_ar * s1_wr;
                p_ii   <= s1_ai * s1_wi;
                p_ri   <= s1_ar * s1_wi;
                p_ir   <= s1_ai * s1_wr;
            end
        end
    end

    // S3 combine: complex sum, round half up, clamp to output range.
    always_comb begin
        re_sum  = SW'(p_rr) - SW'(p_ii);
        im_sum  = SW'(p_ri) + SW'(p_ir);
        re_rnd  = (re_sum + RND_C) >>> FRAC;
        im_rnd  = (im_sum + RND_C) >>> FRAC;
        re_clip = 1'b0;
        im_clip = 1'b0;
        re_o    = re_rnd[OUT_WIDTH-1:0];
        im_o    = im_rnd[OUT_WIDTH-1:0];
        unique case (1'b1)
            re_rnd > O_MAX: begin
                re_o    = OUT_MAX;
                re_clip = 1'b1;
            end
            re_rnd < O_MIN: begin
                re_o    = OUT_MIN;
                re_clip = 1'b1;
            end
            default: ;
        endcase
        unique case (1'b1)
            im_rnd > O_MAX: begin
                im_o    = OUT_MAX;
                im_clip = 1'b1;
            end
            im_rnd < O_MIN: begin
                im_o    = OUT_MIN;
                im_clip = 1'b1;
            end
            default: ;
        endcase
    end

    // S3 outputs: load on valid, otherwise hold; sticky clamp flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            dout1_re  <= '0;
            dout1_im  <= '0;
            dout2_re  <= '0;
            dout2_im  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            valid_out <= s2_v;
            if (s2_v) begin
                dout1_re <= OUT_WIDTH'(s2_d1r);
                dout1_im <= OUT_WIDTH'(s2_d1i);
                dout2_re <= re_o;
                dout2_im <= im_o;
                if (re_clip || im_clip) sat_flag <= 1'b1;
            end
        end
    end

endmodule
